bundle_threshold: RTL and testbench

BUNDLE_THRESHOLD -- requirements
Module: bundle_threshold

---
 rtl/bundle_threshold.sv | 125 ++++++++++++
 tb/tb_bundle_threshold.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bundle_threshold.sv
// bundle_threshold: converts accumulated bundle element sums into a packed
// binary hypervector by majority thresholding against the bundle count N.
// Ties (2*sum == N) are broken by a 16-bit Fibonacci LFSR that advances
// only when a tie is resolved. Output words are emitted with valid/ready.
module bundle_threshold #(
  parameter int          ELEMENT_WIDTH = 64,
  parameter int          COUNT_WIDTH   = 16,
  parameter int          PACK_WIDTH    = 32,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [COUNT_WIDTH-1:0]   count_in,
  input  logic                     overflow_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ELEMENT_WIDTH-1:0] elem_in,
  input  logic                     last_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PACK_WIDTH-1:0]    out_word,
  output logic                     out_last,
  output logic                     busy,
  output logic                     error
);

  localparam int IDX_W = (PACK_WIDTH > 1) ? $clog2(PACK_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PACK_WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] EMIT = 2'd2;

  logic [1:0]             state;
  logic [COUNT_WIDTH-1:0] n_reg;
  logic                   err_reg;
  logic [PACK_WIDTH-1:0]  pack;
  logic [IDX_W-1:0]       idx;
  logic [15:0]            lfsr;
  logic                   last_reg;

  logic                   tie;
  logic                   elem_bit;
  logic [15:0]            lfsr_next;

  // Compare 2*sum against N one bit wider than the sum so the doubling
  // never wraps; N is zero-extended to the same width.
  function automatic logic [1:0] threshold(input logic [ELEMENT_WIDTH-1:0] sum,
                                           input logic [COUNT_WIDTH-1:0]   n);
    logic [ELEMENT_WIDTH:0] twice;
    logic [ELEMENT_WIDTH:0] n_ext;
    twice = {sum, 1'b0};
    n_ext = {{(ELEMENT_WIDTH + 1 - COUNT_WIDTH){1'b0}}, n};
    // {greater, equal}
    return {twice > n_ext, twice == n_ext};
  endfunction

  // Per-element decision, tie resolution and next LFSR value
  always_comb begin
    logic [1:0] cmp;
    cmp       = threshold(elem_in, n_reg);
    tie       = cmp[0];
    elem_bit  = cmp[1] | (cmp[0] & lfsr[0]);
    lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  // Outputs derived directly from state and holding registers
  always_comb begin
    in_ready  = (state == RUN);
    out_valid = (state == EMIT);
    busy      = (state != IDLE);
    out_word  = pack;
    out_last  = last_reg;
    error     = err_reg;
  end

  // Control FSM, pack register and tie-break LFSR
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      n_reg    <= '0;
      err_reg  <= 1'b0;
      pack     <= '0;
      idx      <= '0;
      lfsr     <= LFSR_SEED;
      last_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_reg    <= count_in;
            err_reg  <= overflow_in | (count_in == '0);
            pack     <= '0;
            idx      <= '0;
            last_reg <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (in_valid) begin
            pack[idx] <= elem_bit;
            if (tie) lfsr <= lfsr_next;
            if (last_in || (idx == IDX_MAX)) begin
              last_reg <= last_in;
              state    <= EMIT;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            pack     <= '0;
            idx      <= '0;
            last_reg <= 1'b0;
            state    <= last_reg ? IDLE : RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bundle_threshold.sv
// Directed testbench for bundle_threshold with hand-computed expectations.
module tb_bundle_threshold;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] count_in;
  logic        overflow_in;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] elem_in;
  logic        last_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_last;
  logic        busy;
  logic        error;

  int checks = 0;
  int errors = 0;

  bundle_threshold dut (
    .clk(clk), .reset_n(reset_n), .start(start), .count_in(count_in),
    .overflow_in(overflow_in), .in_valid(in_valid), .in_ready(in_ready),
    .elem_in(elem_in), .last_in(last_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_word(out_word), .out_last(out_last),
    .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [15:0] n, input logic ovf);
    start = 1'b1; count_in = n; overflow_in = ovf;
    tick();
    start = 1'b0; overflow_in = 1'b0;
  endtask

  task automatic send(input logic [63:0] v, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1; elem_in = v; last_in = last;
    while (!in_ready && n < 50) begin tick(); n++; end
    checks++;
    if (!in_ready) begin errors++; $display("FAIL send_timeout in_ready=%0b required 1", in_ready); end
    tick();
    in_valid = 1'b0; last_in = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 0; count_in = 0; overflow_in = 0;
    in_valid = 0; elem_in = 0; last_in = 0; out_ready = 0;
    #1;
    checks++; if ({out_valid, in_ready, busy, error, out_last} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b required 00000", {out_valid, in_ready, busy, error, out_last}); end
    checks++; if (out_word !== 32'h0) begin errors++; $display("FAIL reset_word got %h required 0", out_word); end
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL idle_after_reset valid=%0b busy=%0b required 0 0", out_valid, busy); end
    end
  endtask

  // LFSR tie bits from seed ACE1: 1,0,0,0,0,1
  task automatic test_tie();
    do_start(16'd4, 1'b0);
    checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL run_entry busy=%0b in_ready=%0b required 1 1", busy, in_ready); end
    send(64'd2, 0); send(64'd2, 0); send(64'd2, 1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL tie_valid got %0b required 1", out_valid); end
    checks++; if (out_word !== 32'h0000_0001) begin errors++; $display("FAIL tie_word got %h required 00000001", out_word); end
    checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL tie_last got %0b required 1", out_last); end
    pop();
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL tie_idle busy=%0b valid=%0b required 0 0", busy, out_valid); end
    // ties continue the sequence (0,0,1); the non-tie 3 must not step it
    do_start(16'd4, 1'b0);
    send(64'd2, 0); send(64'd3, 0); send(64'd2, 0); send(64'd2, 1);
    checks++; if (out_word !== 32'h0000_000A) begin errors++; $display("FAIL tie_word2 got %h required 0000000a", out_word); end
    pop();
  endtask

  task automatic test_alternate();
    do_start(16'd5, 1'b0);
    for (int i = 0; i < 32; i++) send((i % 2 == 0) ? 64'd3 : 64'd2, i == 31);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL alt_valid got %0b required 1", out_valid); end
    checks++; if (out_word !== 32'h5555_5555) begin errors++; $display("FAIL alt_word got %h required 55555555", out_word); end
    checks++; if (out_last !== 1'b1 || error !== 1'b0) begin
      errors++; $display("FAIL alt_last_err last=%0b err=%0b required 1 0", out_last, error); end
    pop();
  endtask

  task automatic test_backpressure();
    do_start(16'd3, 1'b0);
    for (int i = 0; i < 32; i++) send(64'd7, 1'b0);
    in_valid = 1'b1; elem_in = 64'd7;
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || out_word !== 32'hFFFF_FFFF || out_last !== 1'b0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL stall_%0d valid=%0b word=%h last=%0b in_ready=%0b required 1 ffffffff 0 0",
                           i, out_valid, out_word, out_last, in_ready); end
      tick();
    end
    in_valid = 1'b0;
    pop();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL resume valid=%0b in_ready=%0b required 0 1", out_valid, in_ready); end
    for (int i = 0; i < 8; i++) send(64'd7, i == 7);
    checks++; if (out_word !== 32'h0000_00FF || out_last !== 1'b1) begin
      errors++; $display("FAIL word2 got %h last=%0b required 000000ff 1", out_word, out_last); end
    pop();
  endtask

  task automatic test_error();
    do_start(16'd10, 1'b1);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL err_ovf got %0b required 1", error); end
    send(64'd6, 0); send(64'd4, 0); send(64'd6, 1);
    checks++; if (out_word !== 32'h0000_0005 || error !== 1'b1) begin
      errors++; $display("FAIL err_pass word=%h err=%0b required 00000005 1", out_word, error); end
    pop();
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL err_hold got %0b required 1", error); end
    do_start(16'd10, 1'b0);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL err_clear got %0b required 0", error); end
    // start while running must be ignored
    start = 1'b1; count_in = 16'd200; overflow_in = 1'b1;
    tick();
    start = 1'b0; overflow_in = 1'b0;
    send(64'd6, 1);
    checks++; if (out_word !== 32'h0000_0001 || error !== 1'b0) begin
      errors++; $display("FAIL start_ignored word=%h err=%0b required 00000001 0", out_word, error); end
    pop();
    do_start(16'd0, 1'b0);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL err_zero got %0b required 1", error); end
    send(64'd1, 1);
    checks++; if (out_word !== 32'h0000_0001) begin errors++; $display("FAIL zero_word got %h required 00000001", out_word); end
    pop();
  endtask

  task automatic test_wide();
    do_start(16'hFFFF, 1'b0);
    send(64'h8000_0000_0000_0000, 0);
    send(64'd32767, 0);
    send(64'd32768, 1);
    checks++; if (out_word !== 32'h0000_0005) begin errors++; $display("FAIL wide_word got %h required 00000005", out_word); end
    pop();
  endtask

  task automatic test_reset_emit();
    do_start(16'd5, 1'b0);
    send(64'd3, 0); send(64'd3, 0); send(64'd3, 1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %0b required 1", out_valid); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({out_valid, in_ready, busy, out_last, error} !== 5'b0 || out_word !== 32'h0) begin
      errors++; $display("FAIL async_reset ctrl=%b word=%h required 00000 0", {out_valid, in_ready, busy, out_last, error}, out_word); end
    start = 1'b1; count_in = 16'd5;
    tick(); tick();
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL start_in_reset busy=%0b in_ready=%0b required 0 0", busy, in_ready); end
    start = 1'b0;
    reset_n = 1'b1;
    tick(); tick();
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset busy=%0b valid=%0b required 0 0", busy, out_valid); end
    // LFSR returns to seed
    do_start(16'd4, 1'b0);
    send(64'd2, 0); send(64'd2, 0); send(64'd2, 1);
    checks++; if (out_word !== 32'h0000_0001) begin errors++; $display("FAIL lfsr_reseed got %h required 00000001", out_word); end
    pop();
  endtask

  initial begin
    test_reset();
    test_tie();
    test_alternate();
    test_backpressure();
    test_error();
    test_wide();
    test_reset_emit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
